writeback_unit: RTL
===================

# writeback_unit

Parametrised write-back stage for the 5-stage RISC-V pipeline. It accepts results from the MEM/WB boundary, selects one of four result sources and aligns/extends sub-word loads. Register-file writes are buffered in a DEPTH-entry queue, so a shared write port (`rf_grant`) can stall write-back without stalling MEM. It also provides a pending-write lookup for hazard logic and a retired-instruction counter.

## Interface
- `XLEN`, 32, datapath width (32 or 64).
- `DEPTH`, 2, write queue entries; power of two, ≥2.
- `CNT_W`, 64, width of the retire counter.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_ready`  out  1  unit can accept this cycle.
- `in_alu_out`  in  XLEN  ALU result; also the load address.
- `in_pc`  in  XLEN  instruction PC.
- `in_imm`  in  XLEN  immediate (LUI path).
- `in_load_data`  in  XLEN  raw aligned word from data memory.
- `in_wb_sel`  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- `in_load_type`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `in_rd`  in  5  destination register.
- `in_we`  in  1  instruction writes rd.
- `rf_grant`  in  1  register-file write port free this cycle.
- `rf_we`  out  1  write request (queue head valid).
- `rf_waddr`  out  5  head destination.
- `rf_wdata`  out  XLEN  head data.
- `lookup_rs`  in  5  source register queried by hazard logic.
- `lookup_hit`  out  1  a queued write targets `lookup_rs`.
- `lookup_data`  out  XLEN  data of youngest matching entry.
- `retire`  out  2  instructions retired this cycle (0–2).
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !full`; it is forced 0 while `rst` is high.
- Write data is selected by `in_wb_sel`:
  - ALU → `in_alu_out`.
  - PC+4 → `in_pc + 4`, modulo 2^XLEN.
  - IMM → `in_imm`.
  - LOAD → aligned/extended data, described below.
- Load alignment uses `off = in_alu_out[1:0]`:
  - LB/LBU → byte `off`, sign- or zero-extended to XLEN.
  - LH/LHU → halfword `off[1]`, sign- or zero-extended.
  - LW → word 0, sign-extended to XLEN when XLEN=64.
  - Any other funct3 → treated as LW.
  - Misaligned halfwords (`off[0]=1`) use `off[1]` only; no trap.
- Non-writers (`in_we=0` or `in_rd=0`) are accepted and retired immediately. They are never queued, and x0 is never written.
- Writers are pushed to the tail. The head drives `rf_we/rf_waddr/rf_wdata`. The head is popped on `rf_we && rf_grant`, and pop order is FIFO.
- Full queue: `in_ready=0`; a pop in the same cycle does not reopen `in_ready` until the next cycle (no `rf_grant`→`in_ready` path).
- Empty queue with push: the entry appears on `rf_we` the next cycle (no bypass from input to port).
- Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo DEPTH.
- Lookup is combinational over valid entries, including the head being popped this cycle. The youngest match wins. `lookup_rs=0` always gives `lookup_hit=0`. The entry being accepted this cycle is not visible to lookup.
- `retire` = (accepted non-writer) + (popped writer). `instret += retire` each cycle, wrapping at 2^CNT_W.

## Timing
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0` (storage cleared), `lookup_hit=0`, `lookup_data=0`, `retire=0`, `instret=0`, queue empty.
- Reset asserted mid-operation discards all queued writes. No partial write is issued after the reset edge.
- Latency from accept to `rf_we` is 1 cycle minimum, plus one cycle per cycle that `rf_grant` is low.
- Throughput is 1 instruction/cycle while `rf_grant=1`.
- `retire` is combinational from the current handshakes. `instret` updates on the following edge.

## Structure
- Shared package `wb_pkg`: `wb_sel_t` enum (ALU, LOAD, PC4, IMM) and funct3 load constants; shared with the decode and MEM stages.
- Sub-module `wb_load_align`: combinational byte/halfword extraction and extension, parameterised by XLEN.
- Top level contains the source mux, the queue (pointers plus count), lookup priority logic and the counter.

## Test plan
- Reset mid-stream: 2 entries queued, assert `rst` → `rf_we=0`, `instret=0`, `in_ready=0` while reset held and 1 after release.
- Load extension, `in_load_data=0x8899AABB`:
  - LB off=1 → `0xFFFFFFAA`.
  - LBU off=3 → `0x00000088`.
  - LH off=2 → `0xFFFF8899`.
  - LHU off=0 → `0x0000AABB`.
- PC+4 path: `in_pc=0xFFFFFFFC`, sel=10, rd=5 → `rf_wdata=0x00000000`, `rf_waddr=5`.
- Stall and full: `rf_grant=0`, push rd=3 then rd=4 → `in_ready=0`, `lookup_rs=4` hits with the second value. Raise `rf_grant` → writes rd=3 then rd=4 in order; `in_ready` returns the cycle after the first pop.
- Retire count: one non-writer accepted in the same cycle as a writer pops → `retire=2`, `instret` +2 next edge. Write to rd=0 → never appears on `rf_we`, counted once.
- Lookup priority: queue holds rd=7 (0x11) then rd=7 (0x22) → `lookup_data=0x22`; `lookup_rs=0` → no hit.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back types: result-source select and load funct3 codes.
// Used by decode, MEM and write-back stages.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Load alignment: picks byte/halfword/word from the raw memory word
// and sign- or zero-extends it to XLEN.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      off,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] result
);

  logic [31:0] w;
  logic [15:0] h;
  logic [7:0]  b;

  always_comb begin
    w = data[31:0];
    b = w[{off, 3'b000} +: 8];
    // misaligned halfwords ignore off[0]
    h = off[1] ? w[31:16] : w[15:0];
    unique case (load_type)
      F3_LB:   result = XLEN'($signed(b));
      F3_LBU:  result = XLEN'(b);
      F3_LH:   result = XLEN'($signed(h));
      F3_LHU:  result = XLEN'(h);
      default: result = XLEN'($signed(w));
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: result mux, buffered register-file write queue,
// pending-write lookup and retired-instruction counter.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_load_data,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_load_type,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  input  logic             rf_grant,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  input  logic [4:0]       lookup_rs,
  output logic             lookup_hit,
  output logic [XLEN-1:0]  lookup_data,
  output logic [1:0]       retire,
  output logic [CNT_W-1:0] instret
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] data_q [DEPTH];
  logic [4:0]      rd_q   [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [PW-1:0]   idx;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wdata;
  logic            full;
  logic            accept;
  logic            writer;
  logic            push;
  logic            pop;
  logic            nonwr;
  wb_sel_t         sel;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .data      (in_load_data),
    .off       (in_alu_out[1:0]),
    .load_type (in_load_type),
    .result    (load_val)
  );

  always_comb begin
    sel = wb_sel_t'(in_wb_sel);
    unique case (sel)
      WB_ALU:  wdata = in_alu_out;
      WB_LOAD: wdata = load_val;
      WB_PC4:  wdata = in_pc + XLEN'(4);
      default: wdata = in_imm;
    endcase
  end

  // in_ready depends only on registered occupancy, never on rf_grant
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full && !rst;
  assign accept   = in_valid && in_ready;
  assign writer   = in_we && (in_rd != 5'd0);
  assign push     = accept && writer;
  assign nonwr    = accept && !writer;

  assign rf_we    = (count != '0);
  assign rf_waddr = rd_q[head];
  assign rf_wdata = data_q[head];
  assign pop      = rf_we && rf_grant;

  assign retire   = {1'b0, nonwr} + {1'b0, pop};

  // walk oldest to youngest so the youngest match overrides
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count && rd_q[idx] == lookup_rs
          && lookup_rs != 5'd0) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      instret <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        data_q[tail] <= wdata;
        rd_q[tail]   <= in_rd;
        tail         <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      instret <= instret + CNT_W'(retire);
    end
  end

endmodule
